// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-back cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } cache_state_t;

  // Tags are stored at a fixed maximum width; the used low bits are TAG_W wide.
  localparam int unsigned MAX_TAG_W = 32;

  typedef struct packed {
    logic                 v;
    logic                 d;
    logic [MAX_TAG_W-1:0] tag;
  } lineMeta_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned offW(input int unsigned wordsPerBlock);
    return clog2(wordsPerBlock) + 2;
  endfunction

  function automatic int unsigned idxW(input int unsigned numLines);
    return clog2(numLines);
  endfunction

  function automatic int unsigned tagW(input int unsigned addrW, input int unsigned numLines,
                                       input int unsigned wordsPerBlock);
    return addrW - idxW(numLines) - offW(wordsPerBlock);
  endfunction

endpackage

// File: rtl/cache_dm_wb_line_store.sv
// Per-line V/D/tag/data storage: indexed read, word write (sets D), block fill, invalidate-all.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned NUM_LINES       = 4,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned TAG_W           = 4
) (
  input  logic                                clk,
  input  logic                                invAll,
  input  logic [clog2(NUM_LINES)-1:0]         rdIdx,
  output lineMeta_t                           rdLine,
  output logic [DATA_W*WORDS_PER_BLOCK-1:0]   rdBlock,
  input  logic                                wrEn,
  input  logic [clog2(NUM_LINES)-1:0]         wrIdx,
  input  logic [clog2(WORDS_PER_BLOCK)-1:0]   wrWord,
  input  logic [DATA_W-1:0]                   wrData,
  input  logic                                fillEn,
  input  logic [clog2(NUM_LINES)-1:0]         fillIdx,
  input  logic [TAG_W-1:0]                    fillTag,
  input  logic [DATA_W*WORDS_PER_BLOCK-1:0]   fillBlock
);

  localparam int unsigned BLK_W = DATA_W * WORDS_PER_BLOCK;

  lineMeta_t        meta [NUM_LINES];
  logic [BLK_W-1:0] data [NUM_LINES];

  assign rdLine  = meta[rdIdx];
  assign rdBlock = data[rdIdx];

  // invAll clears everything, so it doubles as the storage reset.
  always_ff @(posedge clk) begin
    if (invAll) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        meta[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      if (fillEn) begin
        meta[fillIdx] <= '{v: 1'b1, d: 1'b0, tag: MAX_TAG_W'(fillTag)};
        data[fillIdx] <= fillBlock;
      end
      if (wrEn) begin
        meta[wrIdx].d                          <= 1'b1;
        data[wrIdx][wrWord*DATA_W +: DATA_W]   <= wrData;
      end
    end
  end

endmodule

// File: rtl/cache_dm_wb.sv
// Direct-mapped write-back write-allocate cache: FSM, address split and miss sequencing.
// Optional hit/miss/writeback counters are enabled with macro CACHE_STATS_EN.
module cache_dm_wb
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned NUM_LINES       = 4,
  parameter int unsigned WORDS_PER_BLOCK = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cpu_req,
  input  logic                              cpu_we,
  input  logic [ADDR_W-1:0]                 cpu_addr,
  input  logic [DATA_W-1:0]                 cpu_wdata,
  output logic                              cpu_ready,
  output logic [DATA_W-1:0]                 cpu_rdata,
  output logic                              cpu_hit,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W*WORDS_PER_BLOCK-1:0] mem_wdata,
  input  logic [DATA_W*WORDS_PER_BLOCK-1:0] mem_rdata,
  input  logic                              mem_done
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                       stat_hits,
  output logic [31:0]                       stat_misses,
  output logic [31:0]                       stat_writebacks
`endif
);

  localparam int unsigned OFF_W  = offW(WORDS_PER_BLOCK);
  localparam int unsigned IDX_W  = idxW(NUM_LINES);
  localparam int unsigned TAG_W  = tagW(ADDR_W, NUM_LINES, WORDS_PER_BLOCK);
  localparam int unsigned WSEL_W = OFF_W - 2;
  localparam int unsigned BLK_W  = DATA_W * WORDS_PER_BLOCK;

  cache_state_t state, nextState;

  logic              reqWe;
  logic              missFlag;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;

  logic [TAG_W-1:0]  reqTag;
  logic [IDX_W-1:0]  reqIdx;
  logic [WSEL_W-1:0] reqWord;
  logic              unusedByteBits;

  assign reqTag         = reqAddr[ADDR_W-1 -: TAG_W];
  assign reqIdx         = reqAddr[OFF_W +: IDX_W];
  assign reqWord        = reqAddr[2 +: WSEL_W];
  assign unusedByteBits = ^reqAddr[1:0];

  lineMeta_t        rdLine;
  logic [BLK_W-1:0] rdBlock;
  logic             lineHit;
  logic             victimDirty;
  logic             storeEn;
  logic             fillEn;

  assign lineHit     = rdLine.v && (rdLine.tag == MAX_TAG_W'(reqTag));
  assign victimDirty = rdLine.v && rdLine.d;

  cache_line_store #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
    .DATA_W         (DATA_W),
    .TAG_W          (TAG_W)
  ) lineStore (
    .clk      (clk),
    .invAll   (reset),
    .rdIdx    (reqIdx),
    .rdLine   (rdLine),
    .rdBlock  (rdBlock),
    .wrEn     (storeEn),
    .wrIdx    (reqIdx),
    .wrWord   (reqWord),
    .wrData   (reqWdata),
    .fillEn   (fillEn),
    .fillIdx  (reqIdx),
    .fillTag  (reqTag),
    .fillBlock(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reqWe    <= 1'b0;
      reqAddr  <= '0;
      reqWdata <= '0;
      missFlag <= 1'b0;
    end else if (state == IDLE && cpu_req) begin
      reqWe    <= cpu_we;
      reqAddr  <= cpu_addr;
      reqWdata <= cpu_wdata;
      missFlag <= 1'b0;
    end else if (state == COMPARE && !lineHit) begin
      missFlag <= 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:      if (cpu_req) nextState = COMPARE;
      COMPARE: begin
        if (lineHit)          nextState = IDLE;
        else if (victimDirty) nextState = WRITEBACK;
        else                  nextState = ALLOCATE;
      end
      WRITEBACK: if (mem_done) nextState = ALLOCATE;
      ALLOCATE:  if (mem_done) nextState = COMPARE;
      default:   nextState = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    cpu_hit   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    storeEn   = 1'b0;
    fillEn    = 1'b0;
    unique case (state)
      COMPARE: begin
        if (lineHit) begin
          cpu_ready = 1'b1;
          cpu_rdata = rdBlock[reqWord*DATA_W +: DATA_W];
          cpu_hit   = !missFlag;
          storeEn   = reqWe;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rdLine.tag[TAG_W-1:0], reqIdx, {OFF_W{1'b0}}};
        mem_wdata = rdBlock;
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {reqTag, reqIdx, {OFF_W{1'b0}}};
        fillEn   = mem_done;
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic firstHit, firstMiss, wbEntry;

  assign firstHit  = (state == COMPARE) && lineHit && !missFlag;
  assign firstMiss = (state == COMPARE) && !lineHit;
  assign wbEntry   = firstMiss && victimDirty;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (firstHit && stat_hits != '1)        stat_hits       <= stat_hits + 32'd1;
      if (firstMiss && stat_misses != '1)     stat_misses     <= stat_misses + 32'd1;
      if (wbEntry && stat_writebacks != '1)   stat_writebacks <= stat_writebacks + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cache_dm_wb.md
Name: cache_dm_wb

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the main-memory model.
- Generalises the fixed 4-line, 4-word-per-block cache in three ways:
  - configurable address width, line count and block size;
  - a real request/done handshake on both the CPU side and the memory side;
  - a sequenced miss engine: dirty-victim writeback first, then refill.
- Main memory transfers whole blocks per handshake.

Parameters:
ADDR_W, 10, byte-address width
DATA_W, 32, word width (bits); must be 32
NUM_LINES, 4, cache lines; power of two, at least 2
WORDS_PER_BLOCK, 4, words per line; power of two, at least 2

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
cpu_req  in  1  CPU request valid; sampled only in IDLE
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
cpu_wdata  in  DATA_W  store data
cpu_ready  out  1  one-cycle pulse: request complete
cpu_rdata  out  DATA_W  load data, valid while cpu_ready=1
cpu_hit  out  1  valid with cpu_ready: 1 if the original lookup hit
mem_req  out  1  memory request, held until mem_done
mem_we  out  1  1=block writeback, 0=block refill
mem_addr  out  ADDR_W  block-aligned byte address
mem_wdata  out  DATA_W*WORDS_PER_BLOCK  victim block, word 0 in LSBs
mem_rdata  in  DATA_W*WORDS_PER_BLOCK  refill block, word 0 in LSBs
mem_done  in  1  one-cycle completion pulse from memory

Behaviour:
- Address split:
  - OFF_W = log2(WORDS_PER_BLOCK)+2;
  - IDX_W = log2(NUM_LINES);
  - TAG_W = ADDR_W-IDX_W-OFF_W;
  - word select = cpu_addr[OFF_W-1:2].
- Per line: V, D, tag, data block. Storage is flops, reset by reset.
- State machine: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE:
  - when cpu_req=1, latch we/addr/wdata, clear miss flag, go to COMPARE;
  - cpu_req is ignored in every other state.
- COMPARE, hit (V && tag match):
  - cpu_ready=1 this cycle;
  - load: cpu_rdata = addressed word;
  - store: word written at cycle end, D set;
  - cpu_hit = NOT miss flag;
  - next state IDLE.
- COMPARE, miss:
  - set miss flag;
  - go to WRITEBACK if V && D, else to ALLOCATE.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim block;
  - on mem_done go to ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0, mem_addr = {req tag, index, 0};
  - on mem_done write mem_rdata into the line, set V=1, D=0, tag=req tag;
  - return to COMPARE, which now hits.
- Latency:
  - hit: cpu_ready in the cycle after acceptance (2 edges);
  - clean miss: acceptance + 1 + refill wait + 1;
  - dirty miss additionally includes the writeback wait.
- mem_req/mem_we/mem_addr/mem_wdata are constant while in WRITEBACK or ALLOCATE, and are 0 in IDLE and COMPARE.
- mem_done outside WRITEBACK/ALLOCATE is ignored.
- Exactly one line is touched per request; the store merge happens only in COMPARE, never in ALLOCATE.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - all V and D bits 0;
  - tags and data 0.
- Reset mid-operation:
  - abort immediately, mem_req drops next cycle;
  - all lines invalidated and dirty data discarded;
  - no cpu_ready for the aborted request.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - adds outputs stat_hits, stat_misses, stat_writebacks, each 32 bits;
  - counters increment on a first-lookup hit, a first-lookup miss, and entry into WRITEBACK respectively;
  - saturate at all-ones;
  - cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package cache_pkg holds:
  - state enum cache_state_t;
  - localparam helpers for OFF_W/IDX_W/TAG_W (function clog2-based);
  - line record type (V, D, tag).
- One natural sub-module: cache_line_store. It holds the V/D/tag/data arrays with these ports:
  - indexed read;
  - word write with dirty set;
  - block fill;
  - invalidate-all.
- The top module contains the FSM and the address split.

Test Plan:
- Reset, then load 0x004 with mem_rdata block {4,3,2,1}:
  - one ALLOCATE with mem_addr 0x000;
  - cpu_rdata 2, cpu_hit 0.
- Repeat load 0x004:
  - cpu_ready 2 edges after acceptance;
  - cpu_hit 1, rdata 2, no mem_req.
- Store 0xDEAD to 0x008 (hit), then load 0x108 (same index 0, tag differs):
  - WRITEBACK at mem_addr 0x000 with word2 = 0xDEAD;
  - then ALLOCATE at 0x100.
- Miss on a clean line: no WRITEBACK; with mem_done delayed 5 cycles, mem_req is held stable for 5 cycles.
- Assert reset during ALLOCATE:
  - mem_req=0 next cycle, no cpu_ready;
  - subsequent load of the same address misses.
- With CACHE_STATS_EN, run the sequence above: hits=2, misses=2, writebacks=1.
